// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the calculator command sequencer.
// Provides ALU opcode and sub-select constants, the sequencer state
// encoding, default operand/result widths and an opcode validity helper.
package alu_sequencer_pkg;

  localparam int DEF_DATA_W = 80;
  localparam int DEF_RES_W  = 160;

  localparam logic [2:0] OP_ADD   = 3'b001;
  localparam logic [2:0] OP_MUL   = 3'b010;
  localparam logic [2:0] OP_SHIFT = 3'b011;

  localparam logic SEL_ADD = 1'b0;
  localparam logic SEL_SUB = 1'b1;
  localparam logic SEL_SHL = 1'b0;
  localparam logic SEL_SHR = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } seq_state_e;

  function automatic logic is_valid_op(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_MUL) || (op == OP_SHIFT);
  endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Command-side initiator for the calculator ALU.
// Accepts one command at a time (cmd_valid/cmd_ready), drives the ALU
// en/app/sel/a/b inputs, holds en until alu_done, captures alu_c and
// returns it on the result channel (res_valid/res_ready). Invalid opcodes
// and done-timeouts return res_err=1 with res_data=0.
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   cmd_valid/ready/op/sel/a/b  command channel
//   alu_en/app/sel/a/b        registered ALU controls
//   alu_c, alu_done           ALU result and completion
//   res_valid/ready/data/err  result channel
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int RES_W   = DEF_RES_W,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic              cmd_sel,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  output logic              alu_en,
  output logic [2:0]        alu_app,
  output logic              alu_sel,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [RES_W-1:0]  alu_c,
  input  logic              alu_done,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [RES_W-1:0]  res_data,
  output logic              res_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  seq_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              alu_en_q, alu_en_d;
  logic [2:0]        alu_app_q, alu_app_d;
  logic              alu_sel_q, alu_sel_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic              res_valid_q, res_valid_d;
  logic [RES_W-1:0]  res_data_q, res_data_d;
  logic              res_err_q, res_err_d;
  logic              timeout_hit;

  // cnt_q counts completed en-high ISSUE cycles; aborting when it is about
  // to reach TIMEOUT keeps en high for exactly TIMEOUT cycles.
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      alu_en_q    <= 1'b0;
      alu_app_q   <= '0;
      alu_sel_q   <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_en_q    <= alu_en_d;
      alu_app_q   <= alu_app_d;
      alu_sel_q   <= alu_sel_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cmd_valid) state_d = is_valid_op(cmd_op) ? ISSUE : RESP;
      ISSUE:   if (alu_done || timeout_hit) state_d = RESP;
      RESP:    if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    alu_en_d    = alu_en_q;
    alu_app_d   = alu_app_q;
    alu_sel_d   = alu_sel_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_err_d   = res_err_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (cmd_valid) begin
          alu_app_d = cmd_op;
          alu_sel_d = cmd_sel;
          alu_a_d   = cmd_a;
          alu_b_d   = cmd_b;
          if (is_valid_op(cmd_op)) begin
            alu_en_d = 1'b1;
          end else begin
            res_valid_d = 1'b1;
            res_err_d   = 1'b1;
            res_data_d  = '0;
          end
        end
      end
      ISSUE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (alu_done) begin
          alu_en_d    = 1'b0;
          res_valid_d = 1'b1;
          res_err_d   = 1'b0;
          res_data_d  = alu_c;
        end else if (timeout_hit) begin
          alu_en_d    = 1'b0;
          res_valid_d = 1'b1;
          res_err_d   = 1'b1;
          res_data_d  = '0;
        end
      end
      RESP: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          cnt_d       = '0;
        end
      end
      default: ;
    endcase
  end

  assign cmd_ready = rstn && (state_q == IDLE);
  assign alu_en    = alu_en_q;
  assign alu_app   = alu_app_q;
  assign alu_sel   = alu_sel_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_err   = res_err_q;

endmodule
